// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared segment patterns and digit index constants for the scan display
package seg7_pkg;

    // Active-high segment patterns, bit order g..a
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Digit positions on the display (0 = seconds units)
    localparam logic [2:0] IDX_HR_TENS = 3'd5;
    localparam logic [2:0] IDX_COLON_A = 3'd2;
    localparam logic [2:0] IDX_COLON_B = 3'd4;
    localparam logic [2:0] IDX_LAST    = 3'd5;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - BCD nibble to active-high 7-segment pattern
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    // Non-BCD codes show a dash so a corrupted counter is visible
    always_comb begin
        pattern = SEG_DASH;
        case (nibble)
            4'd0: pattern = SEG_0;
            4'd1: pattern = SEG_1;
            4'd2: pattern = SEG_2;
            4'd3: pattern = SEG_3;
            4'd4: pattern = SEG_4;
            4'd5: pattern = SEG_5;
            4'd6: pattern = SEG_6;
            4'd7: pattern = SEG_7;
            4'd8: pattern = SEG_8;
            4'd9: pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - six-digit multiplexed 7-segment scanner with shadow latch, dead time and colon
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int DEAD_CYC   = 16,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [23:0] digits,
    input  logic        sec_pulse,
    input  logic        blank_lz,
    output logic [7:0]  seg,
    output logic [5:0]  an
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] PRE_DEAD = PW'(DEAD_CYC);
    localparam logic [7:0] SEG_OFF = {8{ACTIVE_LOW}};
    localparam logic [5:0] AN_OFF  = {6{ACTIVE_LOW}};

    logic [PW-1:0] prescaler;
    logic [2:0]    idx;
    logic [23:0]   shadow;
    logic          colon_on;
    logic          slot_end;
    logic [3:0]    cur_nibble;
    logic [6:0]    dec_pattern;
    logic [6:0]    seg_pat;
    logic          dp;
    logic [5:0]    an_sel;

    assign slot_end = en && (prescaler == PRE_LAST);

    // Slot timer and digit index; both parked at 0 while disabled so enable restarts a clean frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            idx       <= '0;
        end else if (!en) begin
            prescaler <= '0;
            idx       <= '0;
        end else if (slot_end) begin
            prescaler <= '0;
            idx       <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    // Capture the time once per frame, at the end of the last digit, so a frame never tears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (slot_end && (idx == IDX_LAST)) begin
            shadow <= digits;
        end
    end

    // Colon blinks on the seconds carry even while the display is disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            colon_on <= 1'b0;
        end else if (sec_pulse) begin
            colon_on <= ~colon_on;
        end
    end

    // Select the shadowed nibble for the digit being scanned
    always_comb begin
        cur_nibble = shadow[3:0];
        case (idx)
            3'd0: cur_nibble = shadow[3:0];
            3'd1: cur_nibble = shadow[7:4];
            3'd2: cur_nibble = shadow[11:8];
            3'd3: cur_nibble = shadow[15:12];
            3'd4: cur_nibble = shadow[19:16];
            3'd5: cur_nibble = shadow[23:20];
            default: cur_nibble = shadow[3:0];
        endcase
    end

    seg7_decode u_decode (
        .nibble  (cur_nibble),
        .pattern (dec_pattern)
    );

    // Leading-zero blanking, colon dot and dead-time anode gating in active-high terms
    always_comb begin
        seg_pat = dec_pattern;
        if ((idx == IDX_HR_TENS) && blank_lz && (cur_nibble == 4'd0)) begin
            seg_pat = SEG_BLANK;
        end
        dp     = colon_on && ((idx == IDX_COLON_A) || (idx == IDX_COLON_B));
        an_sel = '0;
        if (prescaler >= PRE_DEAD) begin
            an_sel = 6'd1 << idx;
        end
    end

    // Registered pins, polarity applied at the register input; disabled display is fully dark
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_OFF;
            an  <= AN_OFF;
        end else if (!en) begin
            seg <= SEG_OFF;
            an  <= AN_OFF;
        end else begin
            seg <= SEG_OFF ^ {dp, seg_pat};
            an  <= AN_OFF ^ an_sel;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - self-checking bench for seg7_scan against a frame-level display model
module tb_seg7_scan;

    localparam int SCAN_DIV = 4;
    localparam int DEAD_CYC = 1;
    localparam int FRAME    = 6 * SCAN_DIV;
    localparam logic [6:0] TBL [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [23:0] digits;
    logic        sec_pulse;
    logic        blank_lz;
    logic [7:0]  seg;
    logic [5:0]  an;

    int          tests;
    int          fails;

    int          m_n;
    logic [23:0] m_shadow;
    logic        m_colon;
    logic [7:0]  exp_seg;
    logic [5:0]  exp_an;
    logic        seg_chk;

    seg7_scan #(
        .SCAN_DIV   (SCAN_DIV),
        .DEAD_CYC   (DEAD_CYC),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .digits    (digits),
        .sec_pulse (sec_pulse),
        .blank_lz  (blank_lz),
        .seg       (seg),
        .an        (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pin value expected for time step n since enable: which digit, what it shows, dot
    function automatic logic [7:0] model_seg(int n, logic [23:0] sh, logic col, logic blz);
        int         d;
        logic [3:0] nib;
        logic [6:0] pat;
        logic       dot;
        d   = (n / SCAN_DIV) % 6;
        nib = 4'((sh >> (d * 4)) & 24'hF);
        pat = (nib < 4'd10) ? TBL[nib] : 7'h40;
        if (d == 5 && blz && nib == 4'd0) pat = 7'h00;
        dot = col && (d == 2 || d == 4);
        return ~{dot, pat};
    endfunction

    function automatic logic [5:0] model_an(int n);
        int d;
        d = (n / SCAN_DIV) % 6;
        if ((n % SCAN_DIV) < DEAD_CYC) return 6'h3F;
        return ~(6'(1) << d);
    endfunction

    // Time-step model: global count since enable, frame-boundary capture, toggling colon
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n      <= 0;
            m_shadow <= '0;
            m_colon  <= 1'b0;
            exp_seg  <= 8'hFF;
            exp_an   <= 6'h3F;
            seg_chk  <= 1'b1;
        end else begin
            if (!en) begin
                exp_seg <= 8'hFF;
                exp_an  <= 6'h3F;
                seg_chk <= 1'b1;
                m_n     <= 0;
            end else begin
                exp_seg <= model_seg(m_n, m_shadow, m_colon, blank_lz);
                exp_an  <= model_an(m_n);
                seg_chk <= (m_n % SCAN_DIV) >= DEAD_CYC;
                if ((m_n % FRAME) == FRAME - 1) m_shadow <= digits;
                m_n <= m_n + 1;
            end
            if (sec_pulse) m_colon <= ~m_colon;
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // One cycle: wait for the falling edge, then compare pins against the model
    task automatic tick();
        @(negedge clk);
        chk("an_model", {2'b00, an}, {2'b00, exp_an});
        if (seg_chk) chk("seg_model", seg, exp_seg);
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic align(input int phase);
        for (int i = 0; i < 2 * SCAN_DIV && (m_n % SCAN_DIV) != phase; i++) tick();
        if ((m_n % SCAN_DIV) != phase) begin
            fails++;
            $display("FAIL align timeout: phase %0d wanted %0d", m_n % SCAN_DIV, phase);
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        en        = 1'b0;
        digits    = 24'h0;
        sec_pulse = 1'b0;
        blank_lz  = 1'b0;

        ticks(3);
        chk("reset_seg", seg, 8'hFF);
        chk("reset_an", {2'b00, an}, 8'h3F);
        rst_n = 1'b1;
        tick();
        chk("post_reset_an", {2'b00, an}, 8'h3F);

        en     = 1'b1;
        digits = 24'h123456;
        ticks(26);
        chk("f2_idx0_seg", seg, 8'h82);
        chk("f2_idx0_an", {2'b00, an}, 8'h3E);
        ticks(4);
        chk("f2_idx1_seg", seg, 8'h92);
        chk("f2_idx1_an", {2'b00, an}, 8'h3D);
        ticks(16);
        chk("f2_idx5_seg", seg, 8'hF9);
        chk("f2_idx5_an", {2'b00, an}, 8'h1F);

        ticks(11);
        digits = 24'h000000;
        ticks(5);
        chk("tear_idx3_seg", seg, 8'hB0);
        chk("tear_idx3_an", {2'b00, an}, 8'h37);
        ticks(12);
        chk("f4_idx0_seg", seg, 8'hC0);

        blank_lz = 1'b1;
        digits   = 24'h012359;
        ticks(44);
        chk("blank_seg", seg, 8'hFF);
        chk("blank_an", {2'b00, an}, 8'h1F);
        blank_lz = 1'b0;
        tick();
        chk("noblank_seg", seg, 8'hC0);

        sec_pulse = 1'b1;
        tick();
        sec_pulse = 1'b0;
        ticks(30);
        sec_pulse = 1'b1;
        tick();
        sec_pulse = 1'b0;
        ticks(30);
        align(SCAN_DIV - 1);
        sec_pulse = 1'b1;
        tick();
        sec_pulse = 1'b0;
        ticks(30);

        digits = 24'h0A0B0F;
        ticks(60);

        align(2);
        en = 1'b0;
        tick();
        chk("en_off_an", {2'b00, an}, 8'h3F);
        chk("en_off_seg", seg, 8'hFF);
        ticks(3);
        en = 1'b1;
        ticks(10);

        align(2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_an", {2'b00, an}, 8'h3F);
        chk("async_rst_seg", seg, 8'hFF);
        tick();
        rst_n = 1'b1;
        ticks(30);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Downstream consumer of the digital-clock counter chain: the six BCD time digits (hours, minutes, seconds) multiplex onto a common-segment 7-segment display.
- Time-multiplexed scan with per-frame shadow latch, dead-time ghost suppression, hours-tens leading-zero blanking and a colon blinked by the seconds carry pulse.
- Sits between the counter stages and the board display pins.

Parameters:
- SCAN_DIV, 50000, clk cycles each digit is selected (>= DEAD_CYC+2).
- DEAD_CYC, 16, cycles at start of each digit slot with all anodes off.
- ACTIVE_LOW, 1, 1: seg and an pins are active-low; 0: active-high.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  display enable
- digits  in  24  six BCD nibbles; [3:0]=sec units, [7:4]=sec tens, [11:8]=min units, [15:12]=min tens, [19:16]=hr units, [23:20]=hr tens
- sec_pulse  in  1  one-cycle pulse per second (seconds-units carry)
- blank_lz  in  1  blank hours-tens digit when it is 0
- seg  out  8  [6:0]=segments g..a, [7]=dp
- an  out  6  digit select, an[i] drives digit i

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous, active-low.
- Reset values: prescaler=0, idx=0, shadow=0, colon_on=0. seg and an are all inactive: all 1 when ACTIVE_LOW=1, else all 0.
- Prescaler: counts 0..SCAN_DIV-1 and wraps. The wrap cycle is slot_end.
- At slot_end, idx advances 0..5, then wraps 5->0.
- Shadow latch: on slot_end with idx==5, shadow <= digits. Mid-frame digit changes are invisible until the next frame; no tearing.
- Dead time: anodes are forced inactive while prescaler < DEAD_CYC. Otherwise an[idx] is active and the other anodes are inactive.
- Decode, active-high logical values:
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66
  - 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F
  - 10..15 = 0x40 (dash)
- Blanking: idx==5, blank_lz=1 and shadow[23:20]==0 give segments 0x00. The anode still follows the scan.
- Colon: colon_on toggles on every cycle with sec_pulse=1, independent of en. dp is on for idx==2 or idx==4 when colon_on=1.
- Output register: seg and an are registered. Each output reflects prescaler/idx/shadow state of the previous cycle, i.e. 1-cycle latency.
- Polarity: ACTIVE_LOW=1 inverts both seg and an at the register input.
- en=0: prescaler and idx are held at 0, and seg/an are inactive from the next edge. On en rising, scanning restarts at idx 0 with a full dead time. The shadow does not update while en=0.
- en=1 with sec_pulse on the same cycle as slot_end: both take effect. The new colon value is visible in the new slot.
- Reset mid-scan: outputs go inactive immediately (asynchronous). Scanning resumes from idx 0 after release.

Decomposition:
- Shared package seg7_pkg holds:
  - SEG_* digit pattern constants (0-9, DASH, BLANK)
  - digit index constants IDX_HR_TENS=5, IDX_COLON_A=2, IDX_COLON_B=4
- Sub-module seg7_decode: combinational nibble -> 7-bit pattern. The scan, dead-time, shadow and colon logic stay in seg7_scan.

Test Plan (SCAN_DIV=4, DEAD_CYC=1, ACTIVE_LOW=1):
- Reset then idle → seg=0xFF, an=0x3F during reset and 1 cycle after; no x on outputs.
- en=1, digits=0x123456 → per slot: an inactive 1 cycle, then an=~(1<<idx) with seg=~pattern. Expected sequence 6,5,4,3,2,1 for idx 0..5; frame is 24 cycles. The first frame shows all zeros from the reset shadow.
- digits changed 0x123456→0x000000 at idx==2 → digits 3..5 of the current frame still show 3,2,1; the next frame shows 0s.
- blank_lz=1, digits=0x012359 → idx 5 gives seg=0xFF with an active. blank_lz=0 → seg=~0x3F.
- One sec_pulse → dp lit (seg[7]=0) on idx 2 and 4 only. Second pulse → dp off. Pulse coincident with slot_end also toggles.
- digits nibble 0xA → dash (seg=~0x40). en dropped mid-slot → an=0x3F next edge. rst_n low mid-slot → immediate inactive outputs, restart at idx 0.
